// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter for the shared 8-bit ROM/RAM bus; ownership lasts a whole transfer.
// Optional ARB_TIMEOUT_EN macro adds a stuck-slave timeout that aborts after TIMEOUT owned cycles.
module mem_bus_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_data_out,
  output logic          m0_ready,
  output logic [DW-1:0] m0_data_in,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_data_out,
  output logic          m1_ready,
  output logic [DW-1:0] m1_data_in,
  output logic          s_read,
  output logic          s_write,
  output logic [AW-1:0] s_address,
  output logic [DW-1:0] s_data_out,
  input  logic [DW-1:0] s_data_in,
  input  logic          s_ready,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  // Handshake: a master holds read/write (valid) until it sees its one-cycle ready;
  // dropping the request before ready abandons the transfer with no ready pulse.

  // State encoding is the one-hot grant, so grant doubles as the FSM debug view.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state, state_nx;
  logic   last, last_nx;
  logic   req0, req1;
  logic   own0, own1;
  logic   tmo;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign own0  = (state == OWN0) && !reset;
  assign own1  = (state == OWN1) && !reset;
  assign grant = state;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) state_nx = OWN0;
        else if (req1)               state_nx = OWN1;
      end
      OWN0: begin
        if (!req0 || s_ready || tmo) begin
          last_nx  = 1'b0;
          state_nx = req1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!req1 || s_ready || tmo) begin
          last_nx  = 1'b1;
          state_nx = req0 ? OWN0 : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;

  // Any ownership change (including a zero-gap hand-off) restarts the count.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || state_nx != state) cnt <= '0;
    else                                             cnt <= cnt + 1'b1;
  end

  assign tmo = ((own0 && req0) || (own1 && req1)) && !s_ready && (cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo            = 1'b0;
`endif

  always_comb begin
    s_read     = 1'b0;
    s_write    = 1'b0;
    s_address  = '0;
    s_data_out = '0;
    if (own0) begin
      s_read     = m0_read;
      s_write    = m0_write;
      s_address  = m0_address;
      s_data_out = m0_data_out;
    end else if (own1) begin
      s_read     = m1_read;
      s_write    = m1_write;
      s_address  = m1_address;
      s_data_out = m1_data_out;
    end
  end

  assign m0_ready    = own0 && req0 && (s_ready || tmo);
  assign m1_ready    = own1 && req1 && (s_ready || tmo);
  assign m0_data_in  = tmo ? '0 : s_data_in;
  assign m1_data_in  = tmo ? '0 : s_data_in;
  assign timeout_err = tmo;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed cycle table, stuck-slave sequence, then random traffic
// checked against a transaction-level reference model and a ready/data scoreboard.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_read, m0_write, m1_read, m1_write;
  logic [7:0] m0_address, m0_data_out, m1_address, m1_data_out;
  logic       m0_ready, m1_ready;
  logic [7:0] m0_data_in, m1_data_in;
  logic       s_read, s_write;
  logic [7:0] s_address, s_data_out, s_data_in;
  logic       s_ready;
  logic [1:0] grant;
  logic       timeout_err;

  int nchecks = 0;
  int nerrors = 0;

  mem_bus_arbiter #(.AW(8), .DW(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_data_out(m0_data_out), .m0_ready(m0_ready), .m0_data_in(m0_data_in),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_data_out(m1_data_out), .m1_ready(m1_ready), .m1_data_in(m1_data_in),
    .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_data_out(s_data_out),
    .s_data_in(s_data_in), .s_ready(s_ready), .grant(grant), .timeout_err(timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_bundle();
    return {9'd0, grant, s_read, s_write, s_address, s_data_out, m0_ready, m1_ready, timeout_err};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst;
    logic       r0, w0;
    logic [7:0] a0, d0;
    logic       r1, w1;
    logic [7:0] a1, d1;
    logic       sr;
    logic [7:0] sdi;
    logic [1:0] g;
    logic       srd, swr;
    logic [7:0] sa, sdo;
    logic       rdy0, rdy1;
    logic [7:0] di;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(
    logic rst, logic r0, logic w0, logic [7:0] a0, logic [7:0] d0,
    logic r1, logic w1, logic [7:0] a1, logic [7:0] d1, logic sr, logic [7:0] sdi,
    logic [1:0] g, logic srd, logic swr, logic [7:0] sa, logic [7:0] sdo,
    logic rdy0, logic rdy1, logic [7:0] di);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.sr = sr; v.sdi = sdi;
    v.g = g; v.srd = srd; v.swr = swr; v.sa = sa; v.sdo = sdo;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.di = di;
    return v;
  endfunction

  task automatic drive_inputs(input logic rst, input logic r0, input logic w0,
                              input logic [7:0] a0, input logic [7:0] d0,
                              input logic r1, input logic w1,
                              input logic [7:0] a1, input logic [7:0] d1,
                              input logic sr, input logic [7:0] sdi);
    reset = rst;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_data_out = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_data_out = d1;
    s_ready = sr; s_data_in = sdi;
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      drive_inputs(v.rst, v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1, v.sr, v.sdi);
      #1;
      check($sformatf("vec%0d", i), out_bundle(),
            {9'd0, v.g, v.srd, v.swr, v.sa, v.sdo, v.rdy0, v.rdy1, 1'b0});
      if (v.rdy0) check($sformatf("vec%0d_m0_data_in", i), {24'd0, m0_data_in}, {24'd0, v.di});
      if (v.rdy1) check($sformatf("vec%0d_m1_data_in", i), {24'd0, m1_data_in}, {24'd0, v.di});
    end
  endtask

  // ---------------- stuck slave ----------------
  task automatic run_stuck();
    @(negedge clk);
    drive_inputs(1'b0, 1'b0, 1'b1, 8'h10, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hEE);
    #1;
    check("stuck_idle", {30'd0, grant}, 32'd1 - 32'd1);
    if (TMO_EN) begin
      for (int n = 1; n <= TIMEOUT; n++) begin
        @(negedge clk); #1;
        check($sformatf("tmo_cycle%0d", n), {28'd0, grant, m0_ready, timeout_err},
              (n == TIMEOUT) ? 32'b0111 : 32'b0100);
        if (n == TIMEOUT) check("tmo_data_zero", {24'd0, m0_data_in}, 32'd0);
      end
      @(negedge clk);
      m0_write = 1'b0;
      #1;
      check("tmo_after", {28'd0, grant, m0_ready, timeout_err}, 32'd0);
    end else begin
      for (int n = 1; n <= 100; n++) begin
        @(negedge clk); #1;
        check($sformatf("hold_cycle%0d", n), {27'd0, grant, m0_ready, timeout_err, s_write},
              32'b01001);
      end
      @(negedge clk);
      m0_write = 1'b0;
      #1;
      check("hold_drop", {28'd0, grant, m0_ready, timeout_err}, 32'b0100);
      @(negedge clk); #1;
      check("hold_after", {30'd0, grant}, 32'd0);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  int         mo_owner = -1;  // -1 = nobody owns the bus
  int         mo_last  = 1;
  int         mo_cnt   = 0;
  logic [8:0] exp_q[$];       // {master, read data} per expected ready pulse
  logic       rd[2], wr[2];
  logic [7:0] ad[2], wd[2];
  logic       pend[2];
  logic       prev_rdy[2];

  task automatic model_cycle(input logic rst, input logic sr, input logic [7:0] sdi);
    logic [1:0] g_e;
    logic       srd_e, swr_e, err_e;
    logic [7:0] sa_e, sdo_e, di_e;
    logic       rdy_e[2];
    logic       act, reqk, tmo_e;
    int         k;
    k      = (mo_owner < 0) ? 0 : mo_owner;
    act    = (mo_owner >= 0) && !rst;
    reqk   = rd[k] | wr[k];
    tmo_e  = act && TMO_EN && reqk && !sr && (mo_cnt == TIMEOUT - 1);
    g_e    = (mo_owner < 0) ? 2'b00 : 2'(1 << mo_owner);
    srd_e  = act ? rd[k] : 1'b0;
    swr_e  = act ? wr[k] : 1'b0;
    sa_e   = act ? ad[k] : 8'h00;
    sdo_e  = act ? wd[k] : 8'h00;
    rdy_e[0] = act && (k == 0) && reqk && (sr || tmo_e);
    rdy_e[1] = act && (k == 1) && reqk && (sr || tmo_e);
    err_e  = tmo_e;
    di_e   = tmo_e ? 8'h00 : sdi;
    if (rdy_e[0] || rdy_e[1]) exp_q.push_back({rdy_e[1], di_e});

    check("rand_outputs", out_bundle(),
          {9'd0, g_e, srd_e, swr_e, sa_e, sdo_e, rdy_e[0], rdy_e[1], err_e});

    if (m0_ready || m1_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_ready", 32'd1, 32'd0);
      end else begin
        logic [8:0] exp_t;
        exp_t = exp_q.pop_front();
        check("sb_ready_data", {23'd0, m1_ready, m1_ready ? m1_data_in : m0_data_in},
              {23'd0, exp_t});
      end
    end
    prev_rdy[0] = rdy_e[0];
    prev_rdy[1] = rdy_e[1];

    if (rst) begin
      mo_owner = -1; mo_last = 1; mo_cnt = 0;
    end else if (mo_owner < 0) begin
      if ((rd[0] | wr[0]) && (rd[1] | wr[1])) mo_owner = 1 - mo_last;
      else if (rd[0] | wr[0])                 mo_owner = 0;
      else if (rd[1] | wr[1])                 mo_owner = 1;
      mo_cnt = 0;
    end else if (!reqk || sr || tmo_e) begin
      mo_last  = mo_owner;
      mo_owner = (rd[1-k] | wr[1-k]) ? 1 - k : -1;
      mo_cnt   = 0;
    end else begin
      mo_cnt++;
    end
  endtask

  task automatic run_random(input int cycles);
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; prev_rdy[m] = 1'b0; rd[m] = 1'b0; wr[m] = 1'b0; ad[m] = 8'h00; wd[m] = 8'h00;
    end
    for (int c = 0; c < cycles; c++) begin
      logic rst, sr;
      logic [7:0] sdi;
      @(negedge clk);
      rst = (c == 0) || ($urandom_range(0, 149) == 0);
      for (int m = 0; m < 2; m++) begin
        if (prev_rdy[m] || rst) pend[m] = 1'b0;
        if (pend[m] && $urandom_range(0, 19) == 0) pend[m] = 1'b0;
        else if (!pend[m] && $urandom_range(0, 2) == 0) begin
          int kind;
          kind  = $urandom_range(0, 7);
          rd[m] = (kind == 0) || (kind < 4);
          wr[m] = (kind == 0) || (kind >= 4);
          ad[m] = 8'($urandom);
          wd[m] = 8'($urandom);
          pend[m] = 1'b1;
        end
        if (!pend[m]) begin rd[m] = 1'b0; wr[m] = 1'b0; end
      end
      sr  = ($urandom_range(0, 2) == 0);
      sdi = 8'($urandom);
      drive_inputs(rst, rd[0], wr[0], ad[0], wd[0], rd[1], wr[1], ad[1], wd[1], sr, sdi);
      #1;
      model_cycle(rst, sr, sdi);
    end
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  // ---------------- main ----------------
  initial begin
    drive_inputs(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);

    // reset with pending m0 read, then a single m0 read answered on the third owned cycle
    vecs.push_back(row(1,1,0,8'h85,8'h00, 0,0,8'h00,8'h00, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h85,8'h00, 0,0,8'h00,8'h00, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h85,8'h00, 0,0,8'h00,8'h00, 0,8'h00, 2'b01,1,0,8'h85,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h85,8'h00, 0,0,8'h00,8'h00, 0,8'h00, 2'b01,1,0,8'h85,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h85,8'h00, 0,0,8'h00,8'h00, 1,8'h5A, 2'b01,1,0,8'h85,8'h00,1,0,8'h5A));
    vecs.push_back(row(0,0,0,8'h85,8'h00, 0,0,8'h00,8'h00, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));
    // simultaneous requests after reset: m0 first, zero-gap hand-off to m1
    vecs.push_back(row(1,1,0,8'h12,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h12,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h12,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b01,1,0,8'h12,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h12,8'h00, 0,1,8'h90,8'h33, 1,8'hA5, 2'b01,1,0,8'h12,8'h00,1,0,8'hA5));
    vecs.push_back(row(0,0,0,8'h12,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b10,0,1,8'h90,8'h33,0,0,8'h00));
    vecs.push_back(row(0,0,0,8'h12,8'h00, 0,1,8'h90,8'h33, 1,8'h77, 2'b10,0,1,8'h90,8'h33,0,1,8'h77));
    // m1 writes back to back: one idle cycle between its transfers
    vecs.push_back(row(0,0,0,8'h12,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));
    vecs.push_back(row(0,0,0,8'h12,8'h00, 0,1,8'h90,8'h33, 1,8'h77, 2'b10,0,1,8'h90,8'h33,0,1,8'h77));
    vecs.push_back(row(0,0,0,8'h12,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));
    vecs.push_back(row(0,0,0,8'h12,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b10,0,1,8'h90,8'h33,0,0,8'h00));
    vecs.push_back(row(0,0,0,8'h12,8'h00, 0,1,8'h90,8'h33, 1,8'h77, 2'b10,0,1,8'h90,8'h33,0,1,8'h77));
    // m0 abandons its read, m1 takes over; then reset lands during the m1 transfer
    vecs.push_back(row(0,1,0,8'h20,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h20,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b01,1,0,8'h20,8'h00,0,0,8'h00));
    vecs.push_back(row(0,1,0,8'h20,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b01,1,0,8'h20,8'h00,0,0,8'h00));
    vecs.push_back(row(0,0,0,8'h20,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b01,0,0,8'h20,8'h00,0,0,8'h00));
    vecs.push_back(row(0,0,0,8'h20,8'h00, 0,1,8'h90,8'h33, 0,8'h00, 2'b10,0,1,8'h90,8'h33,0,0,8'h00));
    vecs.push_back(row(1,0,0,8'h20,8'h00, 0,1,8'h90,8'h33, 1,8'h77, 2'b10,0,0,8'h00,8'h00,0,0,8'h00));
    vecs.push_back(row(0,0,0,8'h20,8'h00, 0,0,8'h90,8'h33, 0,8'h00, 2'b00,0,0,8'h00,8'h00,0,0,8'h00));

    run_table();
    run_stuck();
    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
